// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS core's multiply/divide unit.
//   mdu_op_t    : operation selected by the control FSM on start
//   mdu_state_t : sequencing states of mult_div_unit
//   MDU_STEPS   : iteration count of one multiply/divide
package mips_pkg;

  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction for the multiply/divide unit (purely combinational).
//   mag         : unsigned result magnitude; {product} or {remainder, quotient}
//   op          : operation that produced mag
//   sign_a/b    : operand signs (only ever set for signed ops)
//   div_by_zero : divisor was zero
//   dividend    : dividend exactly as given, returned in HI on divide by zero
//   result      : {hi, lo} to commit
module mdu_sign_fix
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] mag,
  input  mdu_op_t                 op,
  input  logic                    sign_a,
  input  logic                    sign_b,
  input  logic                    div_by_zero,
  input  logic [DATA_WIDTH-1:0]   dividend,
  output logic [2*DATA_WIDTH-1:0] result
);

  logic                  is_div;
  logic                  neg;
  logic [DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH-1:0] rem;

  always_comb begin
    is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    neg    = sign_a ^ sign_b;
    quot   = neg    ? -mag[DATA_WIDTH-1:0]            : mag[DATA_WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem    = sign_a ? -mag[2*DATA_WIDTH-1:DATA_WIDTH] : mag[2*DATA_WIDTH-1:DATA_WIDTH];
    if (!is_div)
      result = neg ? -mag : mag;
    else if (div_by_zero)
      result = {dividend, {DATA_WIDTH{1'b1}}};
    else
      result = {rem, quot};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. Holds architectural HI/LO and runs
// MULT/MULTU (shift-add) and DIV/DIVU (restoring) in a fixed 34-edge sequence.
//   clk, reset       : clock, synchronous active-high reset
//   start, op        : begin op when idle
//   mthi, mtlo       : write rs_data to HI/LO when idle
//   rs_data, rt_data : operand A/dividend, operand B/divisor
//   busy, done       : operation in progress, one-cycle completion pulse
//   hi, lo           : architectural HI/LO
//
// state    | meaning
// MDU_IDLE | waiting; accepts start, mthi, mtlo
// MDU_RUN  | one multiply/divide step per edge, count down to 0
// MDU_FIX  | sign fixup, commit HI/LO, pulse done
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEPS      = MDU_STEPS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  mdu_op_t               op,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(STEPS);

  mdu_state_t        state, state_next;
  logic [CW-1:0]     count;
  mdu_op_t           op_q;
  logic              sign_a, sign_b, div_by_zero;
  logic [W-1:0]      dividend, opb;
  logic [2*W-1:0]    acc, acc_step, fixed;
  logic [W-1:0]      hi_q, lo_q;
  logic              done_q;

  logic              is_signed, a_neg, b_neg;
  logic [W-1:0]      mag_a, mag_b;
  logic [W:0]        sum;
  logic [W:0]        rem_trial;
  logic              rem_ge;

  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = is_signed & rs_data[W-1];
    b_neg     = is_signed & rt_data[W-1];
    mag_a     = a_neg ? -rs_data : rs_data;
    mag_b     = b_neg ? -rt_data : rt_data;
  end

  // acc holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  always_comb begin
    sum       = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    rem_trial = acc[2*W-1:W-1];
    rem_ge    = rem_trial >= {1'b0, opb};
    if (op_q == MDU_DIV || op_q == MDU_DIVU)
      // When rem_ge the difference is below opb, so W-bit wraparound is exact.
      acc_step = {rem_ge ? rem_trial[W-1:0] - opb : rem_trial[W-1:0], acc[W-2:0], rem_ge};
    else
      acc_step = {sum, acc[W-1:1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (start) state_next = MDU_RUN;
      MDU_RUN:  if (count == '0) state_next = MDU_FIX;
      MDU_FIX:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      op_q        <= MDU_MULT;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      div_by_zero <= 1'b0;
      dividend    <= '0;
      opb         <= '0;
      acc         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            op_q        <= op;
            sign_a      <= a_neg;
            sign_b      <= b_neg;
            div_by_zero <= (rt_data == '0);
            dividend    <= rs_data;
            opb         <= mag_b;
            acc         <= {{W{1'b0}}, mag_a};
            count       <= CW'(STEPS - 1);
          end else begin
            if (mthi) hi_q <= rs_data;
            if (mtlo) lo_q <= rs_data;
          end
        end
        MDU_RUN: begin
          acc   <= acc_step;
          count <= count - 1'b1;
        end
        MDU_FIX: begin
          {hi_q, lo_q} <= fixed;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  mdu_sign_fix #(.DATA_WIDTH(W)) u_sign_fix (
    .mag         (acc),
    .op          (op_q),
    .sign_a      (sign_a),
    .sign_b      (sign_b),
    .div_by_zero (div_by_zero),
    .dividend    (dividend),
    .result      (fixed)
  );

  assign busy = (state != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit for the multicycle MIPS core. It sits directly downstream of register_file and consumes read_data1 (rs) and read_data2 (rt) to execute MULT, MULTU, DIV, DIVU, MTHI and MTLO. It holds the architectural HI/LO registers, and MFHI/MFLO results return to register_file write_data3 through the writeback mux. It raises busy so the control FSM can stall while a 32-step operation runs.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; only 32 is supported.
STEPS, 32, iteration count (equals DATA_WIDTH).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin op when idle; sampled on rising edge
op  input  2  mdu_op_t: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
mthi  input  1  write rs_data to HI when idle
mtlo  input  1  write rs_data to LO when idle
rs_data  input  32  operand A / dividend (register_file read_data1)
rt_data  input  32  operand B / divisor (register_file read_data2)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: HI/LO just updated by an op
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset is synchronous and active-high. On reset: state IDLE, hi=0, lo=0, busy=0, done=0, and all internal registers cleared. This applies mid-operation too: the op is discarded and HI/LO are cleared.
- States are IDLE, RUN and FIX. busy = (state != IDLE), decoded from state registers.
- Edge E0 is the edge where start=1 is sampled in IDLE:
  - Latch op, the sign flags and the operand magnitudes.
  - Set count=STEPS-1 and go to RUN.
  - Signed ops use the magnitudes |rs| and |rt|; unsigned ops use the raw values.
- RUN, edges E1..E32: one step per edge. After the step where count==0 (edge E32), go to FIX.
  - Multiply uses shift-add on a 64-bit accumulator and produces the product magnitude.
  - Divide uses restoring division on a 33-bit partial remainder and produces quotient and remainder magnitudes.
- FIX, edge E33: apply the sign fixup and write HI/LO; done=1 for the cycle after E33; state returns to IDLE.
  - MULT/MULTU: {hi,lo} = product. For signed ops the product is negated when sign(rs) != sign(rt).
  - DIV/DIVU: lo = quotient, hi = remainder. For signed ops the quotient is negated when signs differ, and the remainder takes the sign of rs.
- Total latency: HI/LO are valid 33 edges after the start-sampling edge. A new start is accepted in the same cycle done is high.
- Divide by zero, any signedness: lo=0xFFFFFFFF, hi=rs_data (dividend as given). This still takes the full 34-edge sequence, so busy timing is data-independent.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude arithmetic with no special case.
- start, mthi or mtlo asserted while busy: ignored with no side effects. The control FSM must not issue them while busy.
- Simultaneous events in IDLE:
  - start has priority; mthi/mtlo are ignored.
  - mthi and mtlo together write both HI and LO from rs_data.
- mthi/mtlo take effect on the sampling edge and are visible the next cycle. done is not asserted for them.
- hi/lo hold their values at all other times and are readable during RUN/FIX. They show the old values until E33.

Decomposition:
- mips_pkg holds:
  - typedef enum logic[1:0] mdu_op_t {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}
  - typedef enum for the state (MDU_IDLE, MDU_RUN, MDU_FIX)
  - localparam MDU_STEPS=32
- One combinational sub-module, mdu_sign_fix. Inputs: 64-bit magnitude result, op, sign_a, sign_b, div_by_zero, original dividend. Output: the final {hi,lo}.

Test Plan:
1. Reset, then MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high for E1..E33; after E33 hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses exactly one cycle.
2. MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with MULT give hi=0, lo=1.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI rs=0x12345678 in idle -> hi=0x12345678 next cycle, done stays 0. MTLO asserted while busy -> lo unchanged.
5. start DIVU 100/7, then a second start with different operands at E10 -> second start ignored; after E33 lo=14, hi=2.
6. Reset asserted at E15 of a MULT -> next cycle busy=0, done=0, hi=lo=0; a fresh DIVU 9/3 then yields lo=3, hi=0 with full 33-edge latency.
